// File: rtl/tree_fanin_half_pkg.sv
// Shared definitions for the width-halving serializer: FSM state encoding
// for the hold register.
package tree_fanin_half_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FIRST  = 2'd1;
    localparam state_t ST_SECOND = 2'd2;

endpackage

// File: rtl/tree_fanin_half.sv
// Width-halving serializer: takes one 2*in_w word per upstream handshake and
// emits it as two in_w beats, backed by a one-entry skid register.
module tree_fanin_half
    import tree_fanin_half_pkg::*;
#(
    parameter int in_w      = 128*8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_vld,
    input  logic [2*in_w-1:0] up_dat,
    output logic              up_rdy,
    output logic              dn_vld,
    input  logic              dn_rdy,
    output logic [in_w-1:0]   dn_dat,
    output logic              dn_last
);

    // Picks the half of a wide word for the given beat (second=0 -> first beat).
    function automatic logic [in_w-1:0] half_sel(input logic [2*in_w-1:0] word,
                                                 input logic              second);
        logic upper;
        upper = second ^ MSB_FIRST;
        return upper ? word[2*in_w-1:in_w] : word[in_w-1:0];
    endfunction

    state_t            state_reg;
    state_t            state_next;
    logic [2*in_w-1:0] h_reg;
    logic [2*in_w-1:0] s_reg;
    logic              s_vld_reg;
    logic              accept;
    logic              h_free;

    // up_rdy comes straight from a flop, so dn_rdy never reaches it combinationally.
    assign up_rdy = ~s_vld_reg;
    assign accept = up_vld & ~s_vld_reg;
    assign h_free = (state_reg == ST_IDLE) || ((state_reg == ST_SECOND) && dn_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FIRST: begin
                if (dn_rdy) state_next = ST_SECOND;
            end
            ST_IDLE, ST_SECOND: begin
                if (h_free) state_next = (s_vld_reg || accept) ? ST_FIRST : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        dn_vld  = (state_reg != ST_IDLE);
        dn_last = (state_reg == ST_SECOND);
        dn_dat  = '0;
        if (state_reg != ST_IDLE) dn_dat = half_sel(h_reg, state_reg == ST_SECOND);
    end

    // The skid entry is always younger than H, so it drains into H before a
    // fresh upstream word may bypass it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_reg     <= '0;
            s_reg     <= '0;
            s_vld_reg <= 1'b0;
        end else if (h_free) begin
            if (s_vld_reg) begin
                h_reg <= s_reg;
                if (accept) begin
                    s_reg <= up_dat;
                end else begin
                    s_vld_reg <= 1'b0;
                end
            end else if (accept) begin
                h_reg <= up_dat;
            end
        end else if (accept) begin
            s_reg     <= up_dat;
            s_vld_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tree_fanin_half.sv
// Bench for tree_fanin_half: an MSB-first and an LSB-first instance share the
// same stimulus; a scoreboard checks every delivered beat against split words.
module tb_tree_fanin_half;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          up_vld;
    logic [2*W-1:0] up_dat;
    logic          dn_rdy;
    logic          up_rdy_w  [2];
    logic          dn_vld_w  [2];
    logic [W-1:0]  dn_dat_w  [2];
    logic          dn_last_w [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    // Expected beats {last, data}; index 0 = MSB-first instance, 1 = LSB-first.
    logic [W:0] exp_q [2][$];

    always #5 clk = ~clk;

    tree_fanin_half #(.in_w(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy_w[0]),
        .dn_vld(dn_vld_w[0]), .dn_rdy(dn_rdy), .dn_dat(dn_dat_w[0]), .dn_last(dn_last_w[0])
    );

    tree_fanin_half #(.in_w(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .up_vld(up_vld), .up_dat(up_dat), .up_rdy(up_rdy_w[1]),
        .dn_vld(dn_vld_w[1]), .dn_rdy(dn_rdy), .dn_dat(dn_dat_w[1]), .dn_last(dn_last_w[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor / scoreboard: pops on every delivered beat, pushes on every accept.
    initial begin
        logic             hold_v    [2];
        logic [W:0]       hold_beat [2];
        logic [W:0]       b;
        hold_v[0] = 1'b0;
        hold_v[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int k = 0; k < 2; k++) begin
                    exp_q[k].delete();
                    hold_v[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (hold_v[k])
                        check(k == 0 ? "stall_hold_msb" : "stall_hold_lsb",
                              {dn_vld_w[k], dn_last_w[k], dn_dat_w[k]}, {1'b1, hold_beat[k]});
                    if (dn_vld_w[k] && dn_rdy) begin
                        if (exp_q[k].size() == 0) begin
                            check(k == 0 ? "spurious_beat_msb" : "spurious_beat_lsb", 64'd1, 64'd0);
                        end else begin
                            b = exp_q[k].pop_front();
                            check(k == 0 ? "beat_msb" : "beat_lsb",
                                  {dn_last_w[k], dn_dat_w[k]}, b);
                            $display("beat inst=%0d dat=%04h last=%0b", k, dn_dat_w[k], dn_last_w[k]);
                        end
                    end
                    hold_v[k]    = dn_vld_w[k] && !dn_rdy;
                    hold_beat[k] = {dn_last_w[k], dn_dat_w[k]};
                end
                check("up_rdy_agree", {63'd0, up_rdy_w[1]}, {63'd0, up_rdy_w[0]});
                if (up_vld && up_rdy_w[0]) begin
                    exp_q[0].push_back({1'b0, up_dat[2*W-1:W]});
                    exp_q[0].push_back({1'b1, up_dat[W-1:0]});
                    exp_q[1].push_back({1'b0, up_dat[W-1:0]});
                    exp_q[1].push_back({1'b1, up_dat[2*W-1:W]});
                    $display("accept word=%08h", up_dat);
                end
            end
        end
    end

    // Offers a word and returns #1 after the edge on which it was accepted.
    task automatic send_word(input logic [2*W-1:0] w);
        bit got;
        got    = 1'b0;
        up_vld = 1'b1;
        up_dat = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (up_rdy_w[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        up_vld = 1'b0;
        dn_rdy = 1'b1;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_drained"}, 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        check({name, "_idle"}, {63'd0, dn_vld_w[0]}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        rst_n  = 1'b0;
        up_vld = 1'b0;
        up_dat = '0;
        dn_rdy = 1'b1;

        // 1: reset values, during and after reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_up_rdy", {63'd0, up_rdy_w[0]}, 64'd1);
        check("rst_dn_vld", {63'd0, dn_vld_w[0]}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_up_rdy", {63'd0, up_rdy_w[0]}, 64'd1);
        check("idle_dn_vld", {63'd0, dn_vld_w[0]}, 64'd0);
        check("idle_dn_dat", {48'd0, dn_dat_w[0]}, 64'd0);
        check("idle_dn_last", {63'd0, dn_last_w[0]}, 64'd0);
        @(posedge clk);
        #1;

        // 2: single word, upper half first
        send_word(32'hAAAA_BBBB);
        up_vld = 1'b0;
        @(negedge clk);
        check("t2_first_vld", {63'd0, dn_vld_w[0]}, 64'd1);
        check("t2_first_dat", {48'd0, dn_dat_w[0]}, 64'hAAAA);
        check("t2_first_last", {63'd0, dn_last_w[0]}, 64'd0);
        @(negedge clk);
        check("t2_second_dat", {48'd0, dn_dat_w[0]}, 64'hBBBB);
        check("t2_second_last", {63'd0, dn_last_w[0]}, 64'd1);
        @(negedge clk);
        check("t2_after_vld", {63'd0, dn_vld_w[0]}, 64'd0);
        @(posedge clk);
        #1;

        // 3: one word every two cycles keeps the beat stream gap-free with up_rdy high
        for (int k = 0; k < 4; k++) begin
            up_vld = 1'b1;
            up_dat = {16'(2*k+1), 16'(2*k+2)};
            @(negedge clk);
            check("t3_up_rdy", {63'd0, up_rdy_w[0]}, 64'd1);
            check("t3_no_gap", {63'd0, dn_vld_w[0]}, {63'd0, k > 0});
            @(posedge clk);
            #1 up_vld = 1'b0;
            @(negedge clk);
            check("t3_up_rdy", {63'd0, up_rdy_w[0]}, 64'd1);
            check("t3_no_gap", {63'd0, dn_vld_w[0]}, 64'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("t3_tail_last", {63'd0, dn_last_w[0]}, 64'd1);
        check("t3_tail_dat", {48'd0, dn_dat_w[0]}, 64'h0008);
        @(negedge clk);
        check("t3_end_vld", {63'd0, dn_vld_w[0]}, 64'd0);
        @(posedge clk);
        #1;

        // 4: downstream stall in FIRST while upstream keeps offering words
        send_word(32'h1111_2222);
        dn_rdy = 1'b0;
        up_vld = 1'b1;
        up_dat = 32'h3333_4444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_dat", {48'd0, dn_dat_w[0]}, 64'h1111);
            check("t4_up_rdy", {63'd0, up_rdy_w[0]}, {63'd0, i == 0});
            @(posedge clk);
            #1;
            if (i == 0) up_dat = 32'h5555_6666;
        end
        dn_rdy = 1'b1;
        send_word(32'h5555_6666);
        drain("t4");

        // 5: reset pulse while in SECOND discards the word
        send_word(32'h9999_8888);
        up_vld = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_dn_vld", {63'd0, dn_vld_w[0]}, 64'd0);
        check("t5_rst_up_rdy", {63'd0, up_rdy_w[0]}, 64'd1);
        check("t5_rst_last", {63'd0, dn_last_w[0]}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(32'h7777_6666);
        up_vld = 1'b0;
        @(negedge clk);
        check("t5_restart_dat", {48'd0, dn_dat_w[0]}, 64'h7777);
        check("t5_restart_last", {63'd0, dn_last_w[0]}, 64'd0);
        drain("t5");

        // 6: LSB-first ordering
        send_word(32'h1234_5678);
        up_vld = 1'b0;
        @(negedge clk);
        check("t6_lsb_first", {48'd0, dn_dat_w[1]}, 64'h5678);
        @(negedge clk);
        check("t6_lsb_second", {48'd0, dn_dat_w[1]}, 64'h1234);
        check("t6_lsb_last", {63'd0, dn_last_w[1]}, 64'd1);
        drain("t6");

        // Random traffic; an offered word stays put until accepted.
        up_vld = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            acc = up_vld && up_rdy_w[0];
            @(posedge clk);
            #1;
            if (!up_vld || acc) begin
                up_vld = ($urandom_range(0, 3) != 0);
                up_dat = $urandom;
            end
            dn_rdy = ($urandom_range(0, 3) != 0);
        end
        drain("random");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
